// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the encrypt_seq block: sequencer state encoding,
// fixed parameter-byte addresses, the output window base and the preamble pad.
// pad_byte() forms one preamble byte from the current LFSR state.
// -----------------------------------------------------------------------------
package enc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_LEN  = 3'd1,
      ST_RD_TAPS = 3'd2,
      ST_RD_SEED = 3'd3,
      ST_LOAD    = 3'd4,
      ST_PRE     = 3'd5,
      ST_MSG     = 3'd6,
      ST_DONE    = 3'd7
   } state_e;

   localparam int unsigned ADDR_LEN  = 32'd61;
   localparam int unsigned ADDR_TAPS = 32'd62;
   localparam int unsigned ADDR_SEED = 32'd63;
   localparam int unsigned OUT_BASE  = 32'd64;
   localparam logic [7:0]  PAD       = 8'h5F;

   function automatic logic [7:0] pad_byte(input logic [5:0] lfsr_s);
      return {2'b00, lfsr_s} ^ PAD;
   endfunction

endpackage

// File: rtl/encrypt_seq_prelen_clamp.sv
// -----------------------------------------------------------------------------
// prelen_clamp
// Combinational clamp of the raw preamble-length byte into [PRE_MIN, PRE_MAX].
// Ports:
//   raw_i : byte read from the length location
//   len_o : clamped preamble length
// -----------------------------------------------------------------------------
module prelen_clamp #(
   parameter int PRE_MIN = 7,
   parameter int PRE_MAX = 142
) (
   input  logic [7:0] raw_i,
   output logic [7:0] len_o
);

   // Clamp raw length to the legal window.
   always_comb begin
      len_o = raw_i;
      if (raw_i < 8'(PRE_MIN)) begin
         len_o = 8'(PRE_MIN);
      end else if (raw_i > 8'(PRE_MAX)) begin
         len_o = 8'(PRE_MAX);
      end else begin
         len_o = raw_i;
      end
   end

endmodule

// File: rtl/encrypt_seq.sv
// -----------------------------------------------------------------------------
// encrypt_seq
// Sequencer that reads preamble length, LFSR taps and seed from memory,
// loads an external 6-bit LFSR, writes a padded preamble and then the
// message XORed with the LFSR stream into the output window at OUT_BASE.
// Optional feature macro: ENCRYPT_SEQ_ABORT_EN adds an abort input that
// returns the sequencer to IDLE without a done pulse.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : request pulse, honoured in IDLE only
//   abort                 : (ENCRYPT_SEQ_ABORT_EN only) cancel a running sequence
//   busy, done            : in-progress flag, one-cycle completion pulse
//   mem_raddr / mem_rdata : combinational memory read port
//   mem_we/waddr/wdata    : memory write port
//   lfsr_state            : current external LFSR value
//   lfsr_en, lfsr_load    : LFSR advance / load strobes
//   taps, seed, pre_len   : registered LFSR configuration and clamped length
// -----------------------------------------------------------------------------
module encrypt_seq
   import enc_pkg::*;
#(
   parameter int AW      = 8,
   parameter int MSG_LEN = 50,
   parameter int PRE_MIN = 7,
   parameter int PRE_MAX = 142
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
`ifdef ENCRYPT_SEQ_ABORT_EN
   input  logic          abort,
`endif
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_raddr,
   input  logic [7:0]    mem_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [7:0]    mem_wdata,
   input  logic [5:0]    lfsr_state,
   output logic          lfsr_en,
   output logic          lfsr_load,
   output logic [5:0]    taps,
   output logic [5:0]    seed,
   output logic [7:0]    pre_len
);

   localparam logic [7:0] MSG_LAST = 8'(MSG_LEN - 1);

   state_e     state_q,   state_d;
   logic [7:0] idx_q,     idx_d;
   logic [7:0] pre_len_q, pre_len_d;
   logic [5:0] taps_q,    taps_d;
   logic [5:0] seed_q,    seed_d;
   logic [7:0] clamp_len_s;
   logic       abort_s;

   prelen_clamp #(
      .PRE_MIN (PRE_MIN),
      .PRE_MAX (PRE_MAX)
   ) u_clamp (
      .raw_i (mem_rdata),
      .len_o (clamp_len_s)
   );

`ifdef ENCRYPT_SEQ_ABORT_EN
   // Abort only matters once a sequence is running.
   assign abort_s = abort & (state_q != ST_IDLE);
`else
   assign abort_s = 1'b0;
`endif

   assign taps    = taps_q;
   assign seed    = seed_q;
   assign pre_len = pre_len_q;

   // Next-state and output decode; every strobe defaults low.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pre_len_d = pre_len_q;
      taps_d    = taps_q;
      seed_d    = seed_q;
      busy      = (state_q != ST_IDLE);
      done      = 1'b0;
      mem_raddr = '0;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = 8'h00;
      lfsr_en   = 1'b0;
      lfsr_load = 1'b0;

      if (abort_s) begin
         // Strobes stay at their defaults; abort wins over everything.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_RD_LEN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RD_LEN: begin
               mem_raddr = AW'(ADDR_LEN);
               pre_len_d = clamp_len_s;
               state_d   = ST_RD_TAPS;
            end
            ST_RD_TAPS: begin
               mem_raddr = AW'(ADDR_TAPS);
               taps_d    = mem_rdata[5:0];
               state_d   = ST_RD_SEED;
            end
            ST_RD_SEED: begin
               mem_raddr = AW'(ADDR_SEED);
               seed_d    = mem_rdata[5:0];
               state_d   = ST_LOAD;
            end
            ST_LOAD: begin
               lfsr_load = 1'b1;
               idx_d     = 8'd0;
               state_d   = ST_PRE;
            end
            ST_PRE: begin
               mem_we    = 1'b1;
               lfsr_en   = 1'b1;
               mem_waddr = AW'(OUT_BASE) + AW'(idx_q);
               mem_wdata = pad_byte(lfsr_state);
               if (idx_q == (pre_len_q - 8'd1)) begin
                  idx_d   = 8'd0;
                  state_d = ST_MSG;
               end else begin
                  idx_d   = idx_q + 8'd1;
               end
            end
            ST_MSG: begin
               mem_raddr = AW'(idx_q);
               mem_we    = 1'b1;
               lfsr_en   = 1'b1;
               // Address wraps modulo 2^AW by truncation of the AW-bit sum.
               mem_waddr = AW'(OUT_BASE) + AW'(pre_len_q) + AW'(idx_q);
               mem_wdata = mem_rdata ^ {2'b00, lfsr_state};
               if (idx_q == MSG_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 8'd1;
               end
            end
            ST_DONE: begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and configuration registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= 8'd0;
         pre_len_q <= 8'd0;
         taps_q    <= 6'd0;
         seed_q    <= 6'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pre_len_q <= pre_len_d;
         taps_q    <= taps_d;
         seed_q    <= seed_d;
      end
   end

endmodule

// File: doc/encrypt_seq.md
ENCRYPT_SEQ -- requirements
Module: encrypt_seq

Interface
REQ-001 SHALL have parameter AW, default 8, memory address width.
REQ-002 SHALL have parameter MSG_LEN, default 50, number of message bytes read from addresses 0..MSG_LEN-1.
REQ-003 SHALL have parameter PRE_MIN, default 7, minimum preamble length.
REQ-004 SHALL have parameter PRE_MAX, default 142, maximum preamble length.
REQ-005 SHALL have ports clk, in, 1, the single clock (all state on its rising edge); rst_n, in, 1, asynchronous active-low reset.
REQ-006 SHALL have ports start, in, 1, request pulse; busy, out, 1, sequence in progress; done, out, 1, one-cycle completion pulse.
REQ-007 SHALL have ports mem_raddr, out, AW; mem_rdata, in, 8, combinational read data for mem_raddr in the same cycle; mem_we, out, 1; mem_waddr, out, AW; mem_wdata, out, 8.
REQ-008 SHALL have ports lfsr_state, in, 6; lfsr_en, out, 1, advance; lfsr_load, out, 1, load taps/seed; taps, out, 6; seed, out, 6; pre_len, out, 8, registered clamped preamble length.

Function
REQ-009 SHALL implement states IDLE, RD_LEN, RD_TAPS, RD_SEED, LOAD, PRE, MSG, DONE, each lasting one cycle except PRE and MSG.
REQ-010 SHALL leave IDLE for RD_LEN on the edge that samples start=1; start in any other state SHALL be ignored.
REQ-011 In RD_LEN, SHALL drive mem_raddr=61 and register pre_len = PRE_MIN if mem_rdata<PRE_MIN, PRE_MAX if mem_rdata>PRE_MAX, else mem_rdata.
REQ-012 In RD_TAPS, SHALL drive mem_raddr=62 and register taps=mem_rdata[5:0]; in RD_SEED, mem_raddr=63 and seed=mem_rdata[5:0].
REQ-013 In LOAD, SHALL assert lfsr_load for exactly one cycle.
REQ-014 In PRE, for i=0..pre_len-1, SHALL assert mem_we and lfsr_en, drive mem_waddr=64+i and mem_wdata={2'b00,lfsr_state}^8'h5F.
REQ-015 In MSG, for j=0..MSG_LEN-1, SHALL drive mem_raddr=j, assert mem_we and lfsr_en, drive mem_waddr=64+pre_len+j and mem_wdata=mem_rdata^{2'b00,lfsr_state}.
REQ-016 An internal 8-bit index counter SHALL clear on entry to PRE and to MSG; address arithmetic SHALL be modulo 2^AW.
REQ-017 In DONE, done SHALL be high for exactly one cycle, then return to IDLE; done high SHALL occur 5+pre_len+MSG_LEN cycles after the start-sampling edge.
REQ-018 busy SHALL be high in every state except IDLE; mem_we, lfsr_en and lfsr_load SHALL be low outside the states above; unused address/data outputs SHALL be 0.
REQ-019 start asserted in the DONE cycle SHALL be ignored; a new start SHALL be accepted from IDLE only.

Reset
REQ-020 rst_n low SHALL immediately force IDLE and set busy, done, mem_we, lfsr_en, lfsr_load to 0 and taps, seed, pre_len, index to 0, including mid-sequence.
REQ-021 After rst_n deasserts, the block SHALL wait in IDLE for start; no partial sequence SHALL resume.

Configuration
REQ-022 With macro ENCRYPT_SEQ_ABORT_EN defined, SHALL add input abort (1 bit): abort=1 in any non-IDLE state SHALL deassert all strobes that cycle and go to IDLE next edge with no done pulse; abort SHALL have priority over start.
REQ-023 Without ENCRYPT_SEQ_ABORT_EN, the abort port SHALL NOT exist and the sequence SHALL always run to DONE.

Structure
REQ-024 A shared package enc_pkg SHALL hold the state enum, addresses 61/62/63, OUT_BASE=64 and the pad constant 8'h5F.
REQ-025 The pre_len clamp SHALL be a sub-module prelen_clamp (combinational, parameterised by PRE_MIN/PRE_MAX); all else SHALL be in encrypt_seq.

Verification
REQ-026 mem[61]=3, mem[62]=6'h21, mem[63]=6'h01, start pulse -> pre_len=7, exactly 7 preamble writes to addresses 64..70, done 62 cycles after start.
REQ-027 mem[61]=10 -> preamble writes 64..73, message writes 74..123, each equal to the reference-model LFSR XOR, done 65 cycles after start.
REQ-028 mem[61]=200 -> pre_len=142, last write at address 255, no write wraps to address 0.
REQ-029 start re-pulsed during PRE and during DONE -> ignored; exactly one done pulse; busy low afterwards.
REQ-030 rst_n low in cycle 20 of MSG -> all outputs 0 in the same cycle; the next start produces a complete, correct run.
REQ-031 ENCRYPT_SEQ_ABORT_EN defined, abort in the 3rd PRE cycle -> strobes low that cycle, IDLE next edge, no done pulse.
